// File: rtl/tiro_nave_if.sv
// Shot-stage bus: control and launch inputs from the game/ship side, shot position and status out.
interface tiro_nave_if;
  logic       pausa;
  logic       reiniciarJogo;
  logic       disparo;
  logic [9:0] xi;
  logic [9:0] yi;
  logic       colisao;
  logic [9:0] x;
  logic [9:0] y;
  logic [9:0] raio;
  logic       ativo;
  logic       fim_tiro;

  modport master (
    output pausa, reiniciarJogo, disparo, xi, yi, colisao,
    input  x, y, raio, ativo, fim_tiro
  );

  modport slave (
    input  pausa, reiniciarJogo, disparo, xi, yi, colisao,
    output x, y, raio, ativo, fim_tiro
  );
endinterface

// File: rtl/tiro_nave.sv
// Allied shot: launches at the ship nose, climbs PASSO pixels per tick, parks off-screen when idle.
// Optional reload delay after each retire is built when TIRO_RECARGA_EN is defined.
module tiro_nave #(
  parameter int unsigned DIV_TICK       = 100000,
  parameter int unsigned PASSO          = 2,
  parameter int unsigned RAIO           = 4,
  parameter int unsigned Y_MIN          = 0,
  parameter int unsigned X_OCULTO       = 1000,
  parameter int unsigned Y_OCULTO       = 1000,
  parameter int unsigned COOLDOWN_TICKS = 50
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  tiro_nave_if.slave   bus
);

  localparam int unsigned      CNT_W     = $clog2(DIV_TICK + 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DIV_TICK - 1);
  localparam logic [9:0]       Y_LIMIT   = 10'(Y_MIN + PASSO);
  localparam logic [9:0]       STEP      = 10'(PASSO);

`ifdef TIRO_RECARGA_EN
  typedef enum logic [1:0] {OCIOSO, VOANDO, RECARGA} state_t;
  localparam state_t APOS_RETIRO = RECARGA;
  localparam int unsigned   CD_W    = $clog2(COOLDOWN_TICKS + 1);
  localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_TICKS - 1);
`else
  typedef enum logic [0:0] {OCIOSO, VOANDO} state_t;
  localparam state_t APOS_RETIRO = OCIOSO;
`endif

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic [9:0]       x_reg;
  logic [9:0]       y_reg;
  logic             fim_reg;
  logic             clear;
  logic             tick;
  logic             at_top;
  logic             launch;
  logic             retire;
  logic             advance;

  assign clear   = reset | bus.reiniciarJogo;
  assign tick    = !bus.pausa && (cnt == TICK_LAST);
  // Compare before subtracting so the shot retires instead of wrapping past the top.
  assign at_top  = (y_reg < Y_LIMIT);
  assign launch  = !bus.pausa && (state == OCIOSO) && bus.disparo;
  assign retire  = !bus.pausa && (state == VOANDO) && (bus.colisao || (tick && at_top));
  assign advance = !bus.pausa && (state == VOANDO) && !bus.colisao && tick && !at_top;

  always_ff @(posedge CLOCK_50) begin
    if (clear) state <= OCIOSO;
    else       state <= nxt;
  end

`ifdef TIRO_RECARGA_EN
  logic [CD_W-1:0] cd;

  always_ff @(posedge CLOCK_50) begin
    if (clear || retire)                cd <= '0;
    else if (state == RECARGA && tick)  cd <= cd + CD_W'(1);
  end
`endif

  always_comb begin
    nxt = state;
    if (!bus.pausa) begin
      case (state)
        OCIOSO:  if (bus.disparo) nxt = VOANDO;
        VOANDO:  if (retire)      nxt = APOS_RETIRO;
`ifdef TIRO_RECARGA_EN
        RECARGA: if (tick && cd == CD_LAST) nxt = OCIOSO;
`endif
        default: nxt = OCIOSO;
      endcase
    end
  end

  // Tick divider restarts on launch so the first step lands DIV_TICK cycles later.
  always_ff @(posedge CLOCK_50) begin
    if (clear) begin
      cnt     <= '0;
      fim_reg <= 1'b0;
    end else if (bus.pausa) begin
      fim_reg <= 1'b0;
    end else begin
      fim_reg <= retire;
      if (launch || cnt == TICK_LAST) cnt <= '0;
      else                            cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (launch) begin
      x_reg <= bus.xi;
      y_reg <= bus.yi;
    end else if (advance) begin
      y_reg <= y_reg - STEP;
    end
  end

  // Coordinates are only meaningful in flight; otherwise the shot is parked.
  always_comb begin
    bus.ativo = (state == VOANDO);
    bus.x     = 10'(X_OCULTO);
    bus.y     = 10'(Y_OCULTO);
    if (state == VOANDO) begin
      bus.x = x_reg;
      bus.y = y_reg;
    end
  end

  assign bus.raio     = 10'(RAIO);
  assign bus.fim_tiro = fim_reg;

endmodule

// File: tb/tb_tiro_nave.sv
// Directed bench for tiro_nave with DIV_TICK=4, PASSO=2, Y_MIN=0, COOLDOWN_TICKS=2.
module tb_tiro_nave;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;

  tiro_nave_if bus();

  tiro_nave #(
    .DIV_TICK(4), .PASSO(2), .RAIO(4), .Y_MIN(0),
    .X_OCULTO(1000), .Y_OCULTO(1000), .COOLDOWN_TICKS(2)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] obs;
  assign obs = {bus.x, bus.y, bus.raio, bus.ativo, bus.fim_tiro};

  function automatic logic [31:0] pack(input int xv, input int yv, input bit a, input bit f);
    return {10'(xv), 10'(yv), 10'd4, a, f};
  endfunction

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    logic [31:0] e;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    e = pack(1000, 1000, 0, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL reset_idle: got %h want %h", obs, e); end
  endtask

  task automatic test_launch_move;
    logic [31:0] e;
    bus.xi = 10'd365; bus.yi = 10'd420; bus.disparo = 1'b1;
    cyc();
    bus.disparo = 1'b0;
    e = pack(365, 420, 1, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL launch: got %h want %h", obs, e); end
    cyc(3);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL pre_step: got %h want %h", obs, e); end
    cyc();
    e = pack(365, 418, 1, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL step1: got %h want %h", obs, e); end
    cyc(4);
    e = pack(365, 416, 1, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL step2: got %h want %h", obs, e); end
    // reset mid-flight
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    e = pack(1000, 1000, 0, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL reset_flight: got %h want %h", obs, e); end
    // game restart overrides pause
    bus.disparo = 1'b1;
    cyc();
    bus.disparo = 1'b0;
    bus.pausa = 1'b1; bus.reiniciarJogo = 1'b1;
    cyc();
    bus.pausa = 1'b0; bus.reiniciarJogo = 1'b0;
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL restart_in_pause: got %h want %h", obs, e); end
  endtask

  task automatic test_top_exit;
    logic [31:0] e;
    bus.xi = 10'd100; bus.yi = 10'd3; bus.disparo = 1'b1;
    cyc();
    bus.disparo = 1'b0;
    cyc(4);
    e = pack(100, 1, 1, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL top_y1: got %h want %h", obs, e); end
    cyc(3);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL top_hold: got %h want %h", obs, e); end
    cyc();
    e = pack(1000, 1000, 0, 1);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL top_retire: got %h want %h", obs, e); end
    cyc();
    e = pack(1000, 1000, 0, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL top_pulse_end: got %h want %h", obs, e); end
  endtask

  task automatic test_collision;
    logic [31:0] e;
    bus.xi = 10'd200; bus.yi = 10'd500; bus.disparo = 1'b1;
    cyc();
    bus.disparo = 1'b0;
    cyc(3);
    e = pack(200, 500, 1, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL coll_pre: got %h want %h", obs, e); end
    bus.colisao = 1'b1;
    cyc();
    bus.colisao = 1'b0;
    e = pack(1000, 1000, 0, 1);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL coll_retire: got %h want %h", obs, e); end
    cyc();
    e = pack(1000, 1000, 0, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL coll_pulse_end: got %h want %h", obs, e); end
  endtask

  task automatic test_pause;
    logic [31:0] e;
    bus.xi = 10'd50; bus.yi = 10'd300; bus.disparo = 1'b1;
    cyc();
    bus.disparo = 1'b0;
    cyc(2);
    bus.pausa = 1'b1;
    cyc(4);
    bus.colisao = 1'b1;
    cyc();
    bus.colisao = 1'b0;
    cyc(5);
    e = pack(50, 300, 1, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL pause_hold: got %h want %h", obs, e); end
    bus.pausa = 1'b0;
    cyc();
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL pause_resume: got %h want %h", obs, e); end
    cyc();
    e = pack(50, 298, 1, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL pause_step: got %h want %h", obs, e); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] e;
    bus.xi = 10'd10; bus.yi = 10'd1; bus.disparo = 1'b1;
    cyc();
    e = pack(10, 1, 1, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL b2b_launch: got %h want %h", obs, e); end
    cyc(4);
    e = pack(1000, 1000, 0, 1);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL b2b_retire: got %h want %h", obs, e); end
`ifdef TIRO_RECARGA_EN
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        vectors++;
        if (bus.ativo !== 1'b0) begin miscompares++; $display("FAIL b2b_cooldown%0d: got %b want 0", i, bus.ativo); end
      end
      cyc();
    end
    vectors++;
    if (bus.ativo !== 1'b0) begin miscompares++; $display("FAIL b2b_cooldown8: got %b want 0", bus.ativo); end
    cyc();
    e = pack(10, 1, 1, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL b2b_relaunch: got %h want %h", obs, e); end
`else
    cyc();
    e = pack(10, 1, 1, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL b2b_relaunch: got %h want %h", obs, e); end
`endif
    bus.disparo = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    bus.pausa         = 1'b0;
    bus.reiniciarJogo = 1'b0;
    bus.disparo       = 1'b0;
    bus.xi            = 10'd0;
    bus.yi            = 10'd0;
    bus.colisao       = 1'b0;
    cyc(2);
    test_reset();
    test_launch_move();
    test_top_exit();
    test_collision();
    test_pause();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tiro_nave.md
Name: tiro_nave

Overview:
Allied projectile stage, directly downstream of the ship block. Accepts a fire request plus launch coordinates (ship nose), then moves the shot upward at a fixed rate. Retires the shot on a top-of-screen exit, a collision, or a game restart. Drives position and radius to the renderer and collision logic; parks the shot off-screen when idle.

Parameters:
DIV_TICK, 100000, CLOCK_50 cycles per motion step (500 steps/s)
PASSO, 2, pixels moved upward per step
RAIO, 4, shot radius driven on raio
Y_MIN, 0, top boundary; shot retires before y would go below it
X_OCULTO, 1000, parked x when idle
Y_OCULTO, 1000, parked y when idle
COOLDOWN_TICKS, 50, steps of reload delay (used only with optional feature)

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
pausa  in  1  1 = freeze all state
reiniciarJogo  in  1  synchronous game restart, same effect as reset
disparo  in  1  fire request, level-sensitive
xi  in  10  launch x (ship x + 15)
yi  in  10  launch y (ship y)
colisao  in  1  shot hit a target; retire shot
x  out  10  shot centre x
y  out  10  shot centre y
raio  out  10  shot radius
ativo  out  1  1 while shot in flight
fim_tiro  out  1  one-cycle pulse when a flight ends

Behaviour:
- Clock and reset: one clock, CLOCK_50. reset is synchronous and active-high. All state changes occur on the CLOCK_50 rising edge.
- Reset or reiniciarJogo (sampled high at an edge):
  - state=OCIOSO, x=X_OCULTO, y=Y_OCULTO, raio=RAIO, ativo=0, fim_tiro=0.
  - Tick counter=0; cooldown counter=0.
  - Overrides pausa and all other inputs.
- raio is constant RAIO at all times, including after reset.
- Tick generator:
  - Counter runs 0..DIV_TICK-1 and asserts internal tick at DIV_TICK-1, then wraps to 0.
  - Cleared to 0 on launch, so the first step lands exactly DIV_TICK cycles after the launch edge.
  - Holds its value while pausa=1.
- pausa=1: no state, counter, or output changes. disparo and colisao are ignored. fim_tiro=0.
- States:
  - OCIOSO: x/y parked, ativo=0. If disparo=1, then at that edge: x<=xi, y<=yi, ativo<=1, go to VOANDO. Launch latency is 1 cycle.
  - VOANDO: evaluated per edge in priority order:
    1. colisao=1 -> retire.
    2. tick and y < Y_MIN+PASSO -> retire (no wrap, no underflow).
    3. tick -> y<=y-PASSO; x unchanged.
    - disparo is ignored in flight; there is only one shot at a time.
  - Retire (one edge): x<=X_OCULTO, y<=Y_OCULTO, ativo<=0, fim_tiro<=1 for exactly one cycle. Next state is OCIOSO, or RECARGA when the feature is enabled.
  - RECARGA (feature only): parked, ativo=0. Counts COOLDOWN_TICKS ticks, then goes to OCIOSO. disparo is ignored.
- Simultaneous events:
  - colisao and tick in the same cycle: colisao wins; no step occurs.
  - reset/reiniciarJogo together with anything: reset wins.
  - disparo held continuously: refires on the first OCIOSO cycle after each retire. This is intended, because the ship holds its request level.
- Widths: all coordinates are 10-bit unsigned. Launch coordinates are taken verbatim with no clamping. x is never modified in flight.

Optional Feature:
- Macro: TIRO_RECARGA_EN.
- Defined: RECARGA state exists. After every retire, the shot waits COOLDOWN_TICKS ticks (the counter freezes under pausa) before OCIOSO accepts disparo.
- Undefined: retire goes straight to OCIOSO. No cooldown counter is built, and COOLDOWN_TICKS is unused.

Test Plan:
(All use DIV_TICK=4, PASSO=2, Y_MIN=0, COOLDOWN_TICKS=2.)
- Reset: assert reset 1 cycle -> x=1000, y=1000, raio=4, ativo=0, fim_tiro=0 on the next edge. Repeat mid-flight -> same values.
- Launch and move: xi=365, yi=420, disparo pulse 1 cycle in OCIOSO -> next edge x=365, y=420, ativo=1. After 4 cycles y=418; after 8 cycles y=416; x stays 365.
- Top exit: launch at yi=3 -> after 4 cycles y=1; at the next tick it retires: fim_tiro high 1 cycle, x=y=1000, ativo=0. y never wraps to 1023.
- Collision priority: colisao=1 on the same cycle as a tick -> retire with no step; fim_tiro pulses once.
- Pause: pausa=1 for 10 cycles mid-flight -> y and ativo unchanged, colisao pulse ignored. After release, the next step comes after the remaining tick count, not restarted.
- Cooldown, with TIRO_RECARGA_EN: disparo held high -> after retire, no relaunch for 8 cycles (2 ticks), then relaunch. Without the macro: relaunch on the cycle after retire.
